dbpsk_symbol_mod: RTL and testbench
===================================

// Module: dbpsk_symbol_mod
// PURPOSE
//   Downstream consumer of the symbol-rate clock produced by the BDPSK clock divider.
//   Detects each rising edge of that divided clock and uses it as the symbol strobe.
//   Takes one data bit per symbol over a valid/ready handshake and differentially encodes it.
//   Outputs a carrier phase word with a 180-degree offset when the encoded bit is 1.
//   phase_o feeds the sine ROM / DAC stage; carrier_o is a square-wave carrier.
// PARAMETERS
//   PHASE_W      10  width of the phase accumulator and of phase_o (bits)
//   FCW          8   frequency control word added to the accumulator every RUN cycle
//   SYNC_STAGES  2   flip-flop stages synchronising sym_clk_i (minimum 2)
// PORTS
//   clk          in   1        system clock (same clock that drives the divider)
//   reset_n      in   1        asynchronous, active-low reset
//   sym_clk_i    in   1        divided symbol clock from the divider (treated as a level)
//   enable_i     in   1        1 = modulate; 0 = return to IDLE
//   bit_valid_i  in   1        upstream data bit valid
//   bit_i        in   1        upstream data bit
//   bit_ready_o  out  1        this block accepts bit_i when bit_valid_i & bit_ready_o
//   sym_stb_o    out  1        one-cycle pulse at each symbol boundary (ARM/RUN only)
//   diff_bit_o   out  1        current differentially encoded symbol
//   phase_o      out  PHASE_W  carrier phase word, including the PSK offset
//   carrier_o    out  1        MSB of phase_o
//   underrun_o   out  1        sticky: a symbol edge arrived with no bit held
//   busy_o       out  1        state != IDLE
// BEHAVIOUR
//   Reset:
//     - All outputs are 0.
//     - state=IDLE; acc=0; hold_v=0; synchroniser flops=0.
//   Edge detect:
//     - sym_clk_i passes through SYNC_STAGES flops, then one more flop (prev).
//     - sym_edge = sync & ~prev.
//     - Latency from sym_clk_i rising to sym_edge is SYNC_STAGES+1 clk.
//     - Falling edges are ignored.
//   Holding register:
//     - One entry (hold_v, hold_bit).
//     - bit_ready_o = (state!=IDLE) & ~hold_v.
//     - An accept sets hold_v and captures bit_i.
//   FSM:
//     - IDLE -> ARM when enable_i=1.
//     - ARM -> RUN on sym_edge.
//     - ARM or RUN -> IDLE the cycle after enable_i=0.
//     - Entering IDLE clears hold_v (the held bit is dropped), diff_bit=0 and acc=0.
//     - The IDLE->ARM transition clears underrun_o.
//   Symbol edge (ARM or RUN):
//     - sym_stb_o=1 for that cycle.
//     - If hold_v=1: diff_bit <= diff_bit ^ hold_bit, and hold_v is cleared.
//     - If hold_v=0: underrun_o <= 1 and diff_bit holds (a 0 is transmitted).
//     - A bit accepted in the same cycle as an underrun edge goes into hold for the next symbol.
//     - In ARM the edge also forces acc <= 0, aligning the carrier with the first symbol.
//   Accumulator:
//     - In RUN, acc <= acc + FCW mod 2^PHASE_W every cycle (wraps silently).
//     - In IDLE and ARM, acc holds 0.
//   phase_o:
//     - Registered: phase_o <= acc + (diff_bit ? 2^(PHASE_W-1) : 0), mod 2^PHASE_W.
//     - Uses the pre-update acc and diff_bit, i.e. one cycle of latency.
//     - In IDLE, phase_o is 0.
//   Asynchronous reset at any time returns every output and state to the reset values.
// TESTING (PHASE_W=10, FCW=8, SYNC_STAGES=2, sym_clk_i = divider N=128 output)
//   1. Reset asserted -> all outputs 0; bit_ready_o=0 while in IDLE.
//   2. Bit preload and first edge:
//      - enable_i=1, preload bit_i=1, then sym_clk_i rises.
//      - sym_stb_o pulses 3 clk later; diff_bit_o=1 on the next cycle.
//      - phase_o=512 on the first RUN output, then steps by 8 per clk.
//   3. Bits 1,0,1,1 on successive edges -> diff_bit_o = 1,1,0,1.
//   4. Underrun and recovery:
//      - No valid before an edge -> underrun_o=1 and diff_bit_o unchanged.
//      - A bit offered in that cycle is accepted and used at the following edge.
//   5. Phase wrap:
//      - 128 RUN cycles with diff_bit=0 -> acc returns to 0.
//      - phase_o goes 1016 -> 0; carrier_o period is 128 clk.
//   6. Abort mid-symbol:
//      - enable_i=0 (or reset_n=0) with hold_v=1.
//      - Next cycle (or immediately, for reset): busy_o=0, bit_ready_o=0, phase_o=0, diff_bit_o=0.
//      - The held bit is discarded.

Source files
------------

// File: rtl/dbpsk_symbol_mod.sv
// dbpsk_symbol_mod: differential BPSK modulator clocked by the divided symbol clock.
// One bit per symbol edge is encoded; the carrier phase carries a 180-degree offset for a 1.
module dbpsk_symbol_mod #(
    parameter int PHASE_W     = 10,
    parameter int FCW         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sym_clk_i,
    input  logic               enable_i,
    input  logic               bit_valid_i,
    input  logic               bit_i,
    output logic               bit_ready_o,
    output logic               sym_stb_o,
    output logic               diff_bit_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               carrier_o,
    output logic               underrun_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN
    } state_t;

    localparam logic [PHASE_W-1:0] W_FCW  = PHASE_W'(FCW);
    localparam logic [PHASE_W-1:0] W_HALF = {1'b1, {(PHASE_W-1){1'b0}}};

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_sym_edge;
    logic                   r_hold_v;
    logic                   r_hold_bit;
    logic                   r_diff;
    logic                   r_underrun;
    logic [PHASE_W-1:0]     r_acc;
    logic [PHASE_W-1:0]     r_phase;

    logic w_active;
    logic w_edge_raw;
    logic w_edge;
    logic w_leave;
    logic w_arm;
    logic w_accept;

    assign w_active   = (r_state != S_IDLE);
    assign w_edge_raw = r_sync[SYNC_STAGES-1] & ~r_prev;
    // the registered edge is the symbol strobe: 3 clk after sym_clk_i rises
    assign w_edge     = r_sym_edge & w_active;
    assign w_leave    = w_active & ~enable_i;
    assign w_arm      = (r_state == S_IDLE) & enable_i;
    assign w_accept   = bit_valid_i & bit_ready_o;

    assign bit_ready_o = w_active & ~r_hold_v;
    assign sym_stb_o   = w_edge;
    assign diff_bit_o  = r_diff;
    assign phase_o     = r_phase;
    assign carrier_o   = r_phase[PHASE_W-1];
    assign underrun_o  = r_underrun;
    assign busy_o      = w_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable_i) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!enable_i) w_state_nxt = S_IDLE;
                else if (w_edge) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_prev     <= 1'b0;
            r_sym_edge <= 1'b0;
            r_hold_v   <= 1'b0;
            r_hold_bit <= 1'b0;
            r_diff     <= 1'b0;
            r_underrun <= 1'b0;
            r_acc      <= '0;
            r_phase    <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sym_clk_i};
            r_prev     <= r_sync[SYNC_STAGES-1];
            r_sym_edge <= w_edge_raw;
            if ((r_state == S_IDLE) || w_leave) begin
                r_hold_v <= 1'b0;
                r_diff   <= 1'b0;
                r_acc    <= '0;
                r_phase  <= '0;
            end else begin
                r_phase <= r_acc + (r_diff ? W_HALF : '0);
                // ARM keeps acc at 0 so the carrier starts aligned to the first symbol
                if (r_state == S_RUN) r_acc <= r_acc + W_FCW;
                else r_acc <= '0;
                if (w_edge && r_hold_v) begin
                    r_diff   <= r_diff ^ r_hold_bit;
                    r_hold_v <= 1'b0;
                end else begin
                    if (w_edge) r_underrun <= 1'b1;
                    if (w_accept) begin
                        r_hold_v   <= 1'b1;
                        r_hold_bit <= bit_i;
                    end
                end
            end
            if (w_arm) r_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbpsk_symbol_mod.sv
// tb_dbpsk_symbol_mod: bench for dbpsk_symbol_mod (PHASE_W=10, FCW=8, SYNC_STAGES=2).
// Encoded bits are queued on each raised symbol edge and compared after each strobe.
module tb_dbpsk_symbol_mod;

    logic       clk;
    logic       reset_n;
    logic       sym_clk_i;
    logic       enable_i;
    logic       bit_valid_i;
    logic       bit_i;
    logic       bit_ready_o;
    logic       sym_stb_o;
    logic       diff_bit_o;
    logic [9:0] phase_o;
    logic       carrier_o;
    logic       underrun_o;
    logic       busy_o;

    int n_chk = 0;
    int n_err = 0;

    logic exp_q[$];
    logic chk_next = 1'b0;
    logic m_diff = 1'b0;

    typedef struct {
        logic b;
        logic exp_diff;
    } vec_t;

    vec_t tbl[6];

    dbpsk_symbol_mod #(
        .PHASE_W    (10),
        .FCW        (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sym_clk_i  (sym_clk_i),
        .enable_i   (enable_i),
        .bit_valid_i(bit_valid_i),
        .bit_i      (bit_i),
        .bit_ready_o(bit_ready_o),
        .sym_stb_o  (sym_stb_o),
        .diff_bit_o (diff_bit_o),
        .phase_o    (phase_o),
        .carrier_o  (carrier_o),
        .underrun_o (underrun_o),
        .busy_o     (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic b);
        int n;
        n = 0;
        bit_valid_i = 1'b1;
        bit_i = b;
        while (bit_ready_o !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("offer_ready", bit_ready_o, 1);
        tick();
        bit_valid_i = 1'b0;
    endtask

    task automatic wait_stb();
        int n;
        n = 0;
        while (sym_stb_o !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("stb_seen", sym_stb_o, 1);
    endtask

    // scoreboard: the cycle after each strobe, diff_bit_o must match the queue head
    always @(negedge clk) begin
        if (chk_next) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_empty: strobe with no expected symbol");
            end else begin
                chk("sb_diff", diff_bit_o, exp_q.pop_front());
            end
        end
        chk_next = reset_n & sym_stb_o;
    end

    initial begin
        int rise0;
        int rise1;
        logic cprev;

        tbl[0] = '{1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0};

        reset_n = 1'b0;
        sym_clk_i = 1'b0;
        enable_i = 1'b0;
        bit_valid_i = 1'b0;
        bit_i = 1'b0;
        repeat (2) tick();
        chk("rst_stb", sym_stb_o, 0);
        chk("rst_diff", diff_bit_o, 0);
        chk("rst_phase", phase_o, 0);
        chk("rst_carrier", carrier_o, 0);
        chk("rst_unr", underrun_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", bit_ready_o, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_ready", bit_ready_o, 0);
        chk("idle_busy", busy_o, 0);

        // preload a 1, then the first symbol edge
        enable_i = 1'b1;
        tick();
        chk("arm_busy", busy_o, 1);
        chk("arm_ready", bit_ready_o, 1);
        offer(1'b1);
        chk("hold_full", bit_ready_o, 0);
        sym_clk_i = 1'b1;
        m_diff = 1'b1;
        exp_q.push_back(1'b1);
        tick();
        tick();
        chk("stb_early", sym_stb_o, 0);
        tick();
        chk("stb_lat3", sym_stb_o, 1);
        tick();
        chk("diff_first", diff_bit_o, 1);
        chk("stb_one_cycle", sym_stb_o, 0);
        chk("phase_arm", phase_o, 0);
        sym_clk_i = 1'b0;
        tick();
        chk("phase_first_run", phase_o, 512);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("phase_step", phase_o, 512 + 8 * k);
        end
        chk("carrier_hi", carrier_o, 1);

        // re-arm to restart encoding from 0
        enable_i = 1'b0;
        tick();
        chk("dis_busy", busy_o, 0);
        chk("dis_phase", phase_o, 0);
        chk("dis_diff", diff_bit_o, 0);
        m_diff = 1'b0;
        enable_i = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 6; i++) begin
            offer(tbl[i].b);
            sym_clk_i = 1'b1;
            exp_q.push_back(tbl[i].exp_diff);
            m_diff = tbl[i].exp_diff;
            wait_stb();
            tick();
            chk("tbl_unr", underrun_o, 0);
            sym_clk_i = 1'b0;
            repeat (4) tick();
        end

        // underrun edge with a bit accepted in the same cycle
        chk("unr_before", underrun_o, 0);
        sym_clk_i = 1'b1;
        exp_q.push_back(m_diff);
        wait_stb();
        bit_valid_i = 1'b1;
        bit_i = 1'b1;
        tick();
        bit_valid_i = 1'b0;
        chk("unr_set", underrun_o, 1);
        chk("unr_held", bit_ready_o, 0);
        chk("unr_diff", diff_bit_o, m_diff);
        sym_clk_i = 1'b0;
        repeat (4) tick();
        sym_clk_i = 1'b1;
        m_diff = ~m_diff;
        exp_q.push_back(m_diff);
        wait_stb();
        tick();
        chk("recover_diff", diff_bit_o, m_diff);
        chk("recover_ready", bit_ready_o, 1);
        chk("unr_sticky", underrun_o, 1);
        sym_clk_i = 1'b0;
        repeat (4) tick();

        // phase wrap with diff_bit=0
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
        chk("rearm_unr_clr", underrun_o, 0);
        m_diff = 1'b0;
        sym_clk_i = 1'b1;
        exp_q.push_back(1'b0);
        wait_stb();
        sym_clk_i = 1'b0;
        rise0 = -1;
        rise1 = -1;
        cprev = carrier_o;
        for (int j = 1; j <= 200; j++) begin
            tick();
            if (j == 2) chk("wrap_start", phase_o, 0);
            if (j == 3) chk("wrap_step", phase_o, 8);
            if (j == 129) chk("wrap_top", phase_o, 1016);
            if (j == 130) chk("wrap_zero", phase_o, 0);
            if (carrier_o && !cprev) begin
                if (rise0 < 0) rise0 = j;
                else if (rise1 < 0) rise1 = j;
            end
            cprev = carrier_o;
        end
        chk("carrier_rise", rise0, 66);
        chk("carrier_period", rise1 - rise0, 128);

        // abort with a bit held
        offer(1'b1);
        sym_clk_i = 1'b1;
        m_diff = 1'b1;
        exp_q.push_back(1'b1);
        wait_stb();
        tick();
        sym_clk_i = 1'b0;
        repeat (4) tick();
        offer(1'b1);
        chk("abort_held", bit_ready_o, 0);
        enable_i = 1'b0;
        tick();
        m_diff = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_ready", bit_ready_o, 0);
        chk("abort_phase", phase_o, 0);
        chk("abort_diff", diff_bit_o, 0);
        enable_i = 1'b1;
        tick();
        chk("abort_dropped", bit_ready_o, 1);
        sym_clk_i = 1'b1;
        exp_q.push_back(1'b0);
        wait_stb();
        tick();
        chk("abort_unr", underrun_o, 1);
        sym_clk_i = 1'b0;
        repeat (4) tick();

        // asynchronous reset with a bit held
        offer(1'b1);
        sym_clk_i = 1'b1;
        exp_q.push_back(1'b1);
        wait_stb();
        tick();
        sym_clk_i = 1'b0;
        repeat (4) tick();
        chk("pre_rst_diff", diff_bit_o, 1);
        offer(1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_ready", bit_ready_o, 0);
        chk("arst_phase", phase_o, 0);
        chk("arst_diff", diff_bit_o, 0);
        chk("arst_unr", underrun_o, 0);
        chk("arst_carrier", carrier_o, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", bit_ready_o, 1);
        enable_i = 1'b0;
        repeat (3) tick();
        chk("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
